// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types, constants and helpers for the iterative
//                restoring divider (div_iter_param / div_step).
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package div_pkg;

    // Divider control states
    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_ZERO = 3'd1,
        DIV_ON   = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_END  = 3'd4
    } div_state_t;

    // Widest operand the sign helper handles
    localparam int DIV_MAX_W = 64;

    // Bit n set means STEP = n quotient bits per cycle is supported (1, 2, 4)
    localparam int unsigned DIV_STEP_LEGAL = 32'h0000_0016;

    // Conditional two's-complement negate; callers truncate to their width,
    // which is exact because negation is modular
    function automatic logic [DIV_MAX_W-1:0] abs_twos(
        input logic [DIV_MAX_W-1:0] val,
        input logic                 neg
    );
        return neg ? (~val + {{(DIV_MAX_W-1){1'b0}}, 1'b1}) : val;
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : Combinational chain of STEP restoring-division stages.
//                Each stage shifts in one dividend bit, trial-subtracts the
//                divisor at WIDTH+1 bits and keeps the difference when no
//                borrow occurs.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [STEP-1:0]  i_dbits,    // next dividend bits, MSB first
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [STEP-1:0]  o_qbits     // quotient bits, MSB first
);

    logic [WIDTH-1:0] w_rem_chain [0:STEP];

    assign w_rem_chain[0] = i_rem;

    for (genvar gi = 0; gi < STEP; gi++) begin : g_stage
        logic [WIDTH:0] w_shift;
        logic [WIDTH:0] w_diff;
        logic           w_borrow;

        // Shift in one dividend bit and trial-subtract; bit WIDTH is the borrow
        assign w_shift  = {w_rem_chain[gi], i_dbits[STEP-1-gi]};
        assign w_diff   = w_shift - {1'b0, i_divisor};
        assign w_borrow = w_diff[WIDTH];

        assign o_qbits[STEP-1-gi]  = ~w_borrow;
        // On borrow the shifted value is below the divisor, so it fits WIDTH
        assign w_rem_chain[gi+1]   = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end

    assign o_rem = w_rem_chain[STEP];

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter_param.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_param
//  Description : Parametrised multi-cycle restoring integer divider for the
//                EX stage. Signed/unsigned, STEP quotient bits per cycle,
//                explicit divide-by-zero result and start/annul/ready
//                handshake. result_o = {remainder, quotient}.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module div_iter_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int CNT_W = $clog2(WIDTH/STEP) + 1
) (
    input  logic               clk,
    input  logic               rst,          // synchronous, active low
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic               busy_o
);

    localparam logic [CNT_W-1:0] c_iters = CNT_W'(WIDTH/STEP);

    // Reject unsupported parameter combinations at elaboration
    if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (WIDTH > DIV_MAX_W) ||
        (STEP < 1) || (((DIV_STEP_LEGAL >> STEP) & 32'd1) == 32'd0) ||
        ((WIDTH % STEP) != 0)) begin : g_bad_params
        $error("div_iter_param: illegal WIDTH/STEP combination");
    end

    div_state_t         r_state;
    div_state_t         w_state_next;

    logic               r_s1;
    logic               r_s2;
    logic               r_signed;
    logic               r_dz;
    logic               r_ready;
    logic [WIDTH-1:0]   r_op1_raw;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_dq;        // unconsumed dividend bits, quotient shifts in below
    logic [WIDTH-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_op2_zero;
    logic               w_s1;
    logic               w_s2;
    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;
    logic [WIDTH-1:0]   w_rem_next;
    logic [STEP-1:0]    w_qbits;
    logic [WIDTH-1:0]   w_dq_next;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept   = start_i & ~annul_i;
    assign w_op2_zero = (opdata2_i == '0);
    assign w_s1       = signed_div_i & opdata1_i[WIDTH-1];
    assign w_s2       = signed_div_i & opdata2_i[WIDTH-1];
    assign w_op1_mag  = WIDTH'(abs_twos(DIV_MAX_W'(opdata1_i), w_s1));
    assign w_op2_mag  = WIDTH'(abs_twos(DIV_MAX_W'(opdata2_i), w_s2));

    div_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_rem     (r_rem),
        .i_dbits   (r_dq[WIDTH-1 -: STEP]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_qbits   (w_qbits)
    );

    assign w_dq_next  = (r_dq << STEP) | WIDTH'(w_qbits);
    assign w_cnt_inc  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    // Quotient sign is the XOR of operand signs; remainder follows the dividend
    assign w_quot_fix = WIDTH'(abs_twos(DIV_MAX_W'(r_dq), r_signed & (r_s1 ^ r_s2)));
    assign w_rem_fix  = WIDTH'(abs_twos(DIV_MAX_W'(r_rem), r_s1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_op2_zero ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: w_state_next = annul_i ? DIV_IDLE : DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    w_state_next = DIV_IDLE;
                end else if (w_cnt_inc == c_iters) begin
                    w_state_next = DIV_FIX;
                end
            end
            DIV_FIX:  w_state_next = annul_i ? DIV_IDLE : DIV_END;
            DIV_END: begin
                if (!start_i) begin
                    w_state_next = DIV_IDLE;
                end
            end
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/handshake registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_signed  <= 1'b0;
            r_dz      <= 1'b0;
            r_ready   <= 1'b0;
            r_op1_raw <= '0;
            r_divisor <= '0;
            r_dq      <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_s1      <= w_s1;
                        r_s2      <= w_s2;
                        r_signed  <= signed_div_i;
                        r_op1_raw <= opdata1_i;
                        r_divisor <= w_op2_mag;
                        r_dq      <= w_op1_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_dz      <= 1'b0;
                    end
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        r_rem <= w_rem_next;
                        r_dq  <= w_dq_next;
                        r_cnt <= w_cnt_inc;
                    end
                end
                DIV_FIX: begin
                    if (!annul_i) begin
                        r_result <= {w_rem_fix, w_quot_fix};
                    end
                end
                DIV_ZERO: begin
                    if (!annul_i) begin
                        r_result <= {r_op1_raw, {WIDTH{1'b1}}};
                        r_dz     <= 1'b1;
                    end
                end
                DIV_END: begin
                    if (start_i) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_ready  <= 1'b0;
                        r_dz     <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign div_zero_o = r_ready & r_dz;
    assign busy_o     = (r_state != DIV_IDLE);

endmodule : div_iter_param
`default_nettype wire

// File: tb/tb_div_iter_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter_param
//  Description : Self-checking bench for div_iter_param. Three instances
//                (STEP = 1, 2, 4, WIDTH = 32) share one stimulus stream;
//                each is checked for latency, result, flags and clearing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_param;

    localparam int W    = 32;
    localparam int ND   = 3;
    localparam int HOLD = 36;

    logic            clk;
    logic            rst;
    logic            signed_div;
    logic [W-1:0]    op1;
    logic [W-1:0]    op2;
    logic            start;
    logic            annul;
    logic [2*W-1:0]  res  [ND];
    logic            rdy  [ND];
    logic            dz   [ND];
    logic            busy [ND];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar gd = 0; gd < ND; gd++) begin : g_dut
        div_iter_param #(
            .WIDTH (W),
            .STEP  ((gd == 0) ? 1 : ((gd == 1) ? 2 : 4))
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .signed_div_i (signed_div),
            .opdata1_i    (op1),
            .opdata2_i    (op2),
            .start_i      (start),
            .annul_i      (annul),
            .result_o     (res[gd]),
            .ready_o      (rdy[gd]),
            .div_zero_o   (dz[gd]),
            .busy_o       (busy[gd])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    // Reference: plain arithmetic; returns {div_zero, remainder, quotient}
    function automatic logic [2*W:0] model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q64;
        longint r64;
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q64 = sa / sb;
            r64 = sa % sb;
            q   = q64[W-1:0];
            r   = r64[W-1:0];
        end
        return {1'b0, r, q};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_clear(input string tag, input int d);
        chk($sformatf("%s d%0d busy", tag, d), 64'(busy[d]), 64'd0);
        chk($sformatf("%s d%0d ready", tag, d), 64'(rdy[d]), 64'd0);
        chk($sformatf("%s d%0d dz", tag, d), 64'(dz[d]), 64'd0);
        chk($sformatf("%s d%0d result", tag, d), res[d], 64'd0);
    endtask

    // Issue one operation to all instances, hold start, then release it
    task automatic run_op(input string tag, input bit sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp_res,
                          input bit exp_dz, input bit toggle);
        int          first [ND];
        int          lat   [ND];
        logic [63:0] fres  [ND];
        logic        fdz   [ND];
        for (int d = 0; d < ND; d++) begin
            first[d] = -1;
            fres[d]  = '0;
            fdz[d]   = 1'b0;
            lat[d]   = exp_dz ? 2 : (W / step_of(d)) + 2;
        end
        signed_div = sgn;
        op1        = a;
        op2        = b;
        annul      = 1'b0;
        start      = 1'b1;
        tick();                                 // accepting edge T
        for (int k = 1; k <= HOLD; k++) begin
            if (toggle) begin
                op1        = $urandom;
                op2        = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
            tick();
            for (int d = 0; d < ND; d++) begin
                if (rdy[d] === 1'b1 && first[d] < 0) begin
                    first[d] = k;
                    fres[d]  = res[d];
                    fdz[d]   = dz[d];
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s d%0d latency", tag, d), 64'(first[d]), 64'(lat[d]));
            chk($sformatf("%s d%0d result", tag, d), fres[d], exp_res);
            chk($sformatf("%s d%0d div_zero", tag, d), 64'(fdz[d]), 64'(exp_dz));
            chk($sformatf("%s d%0d hold", tag, d), {63'(rdy[d]), 1'b0} | 64'(res[d] !== exp_res), 64'd2);
        end
        start = 1'b0;
        op1   = '0;
        op2   = '0;
        tick();
        for (int d = 0; d < ND; d++) chk_all_clear({tag, " clear"}, d);
    endtask

    typedef struct {
        bit          sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [63:0] exp_res;
        bit          exp_dz;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [2*W:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,        32'd14},       1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,        32'hFFFFFFFD}, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,        32'h80000000}, 1'b0};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,        32'hFFFFFFFF}, 1'b0};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          {32'd5,        32'hFFFFFFFF}, 1'b1};
        vecs[6]  = '{1'b1, 32'd5,          32'd0,          {32'd5,        32'hFFFFFFFF}, 1'b1};
        vecs[7]  = '{1'b0, 32'd1000,       32'd10,         {32'd0,        32'd100},      1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3},        1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1,        32'h7FFFFFFC}, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,          {32'hFFFFFFF9, 32'hFFFFFFFF}, 1'b1};
        vecs[11] = '{1'b0, 32'd3,          32'd5,          {32'd3,        32'd0},        1'b0};

        rst        = 1'b0;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < ND; d++) chk_all_clear("reset", d);
        rst = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].exp_res, vecs[i].exp_dz, 1'b0);
        end

        // Annul after 10 ON cycles: STEP=1/2 abort, STEP=4 is already in END
        signed_div = 1'b0;
        op1        = 32'd123456;
        op2        = 32'd3;
        start      = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) chk("annul busy-during-op d0", 64'(busy[0]), 64'd1);
        end
        annul = 1'b1;
        tick();
        chk("annul d0 busy", 64'(busy[0]), 64'd0);
        chk("annul d0 ready", 64'(rdy[0]), 64'd0);
        chk("annul d1 busy", 64'(busy[1]), 64'd0);
        chk("annul d1 ready", 64'(rdy[1]), 64'd0);
        chk("annul-in-END d2 ready", 64'(rdy[2]), 64'd1);
        chk("annul-in-END d2 result", res[2], {32'd0, 32'd41152});
        start = 1'b0;
        annul = 1'b0;
        tick();
        for (int d = 0; d < ND; d++) chk_all_clear("post-annul", d);
        run_op("after-annul", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0, 1'b1);

        // Reset mid-operation
        signed_div = 1'b1;
        op1        = 32'hFFFFFF00;
        op2        = 32'd9;
        start      = 1'b1;
        tick();
        repeat (5) tick();
        rst = 1'b0;
        tick();
        for (int d = 0; d < ND; d++) chk_all_clear("midreset", d);
        rst   = 1'b1;
        start = 1'b0;
        tick();
        for (int d = 0; d < ND; d++) chk_all_clear("post-reset", d);
        run_op("after-reset", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);

        // Random vectors against the reference model, buses toggled after T
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       begin rb = 32'hFFFFFFFF; ra = 32'h80000000; end
                3:       rb = 32'($urandom_range(1, 65535));
                default: rb = $urandom;
            endcase
            m = model(rs, ra, rb);
            run_op($sformatf("rand%0d", i), rs, ra, rb, m[2*W-1:0], m[2*W], 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_div_iter_param
`default_nettype wire
